// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the writeback ports among functional-unit result
// sources. Grants the oldest pending results in active-list age order, squashes
// results younger than a mispredicted branch, and registers the winners onto
// the writeback bus one cycle after the grant.
module wb_port_arbiter #(
  parameter int NUM_REQ   = 6,
  parameter int NUM_PORTS = 4,
  parameter int AL_SIZE   = 64,
  parameter int NUM_PR    = 64,
  parameter int DATA_W    = 64,
  localparam int AW = $clog2(AL_SIZE),
  localparam int PW = $clog2(NUM_PR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [AW-1:0]      req_al_idx  [NUM_REQ],
  input  logic [NUM_REQ-1:0] req_uses_rd,
  input  logic [PW-1:0]      req_rd      [NUM_REQ],
  input  logic [DATA_W-1:0]  req_data    [NUM_REQ],
  input  logic [AW-1:0]      al_head,
  input  logic               flush,
  input  logic [AW-1:0]      flush_al_idx,
  output logic [NUM_PORTS-1:0] wb_valid,
  output logic [AW-1:0]      wb_al_idx   [NUM_PORTS],
  output logic [NUM_PORTS-1:0] wb_uses_rd,
  output logic [PW-1:0]      wb_rd       [NUM_PORTS],
  output logic [DATA_W-1:0]  wb_data     [NUM_PORTS],
  output logic [15:0]        conflict_cnt
);

  localparam int RW = $clog2(NUM_REQ + 1);

  logic [AW-1:0]        age [NUM_REQ];
  logic [AW-1:0]        flush_age;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   squash;
  logic [NUM_REQ-1:0]   grant;
  logic [RW-1:0]        rank [NUM_REQ];
  logic [RW-1:0]        elig_cnt;

  logic [NUM_PORTS-1:0] sel_valid;
  logic [AW-1:0]        sel_al_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] sel_uses_rd;
  logic [PW-1:0]        sel_rd     [NUM_PORTS];
  logic [DATA_W-1:0]    sel_data   [NUM_PORTS];

  // Ages relative to the commit head (wrapping subtraction); younger-than-branch requests are squashed
  always_comb begin : age_calc
    flush_age = flush_al_idx - al_head;
    for (int i = 0; i < NUM_REQ; i++) begin
      age[i]      = req_al_idx[i] - al_head;
      squash[i]   = flush && req_valid[i] && (age[i] > flush_age);
      eligible[i] = req_valid[i] && !squash[i];
    end
  end

  // Rank each eligible request by how many eligible requests are older (ties go to lower index)
  always_comb begin : rank_calc
    elig_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rank[i]  = '0;
      elig_cnt = elig_cnt + RW'(eligible[i]);
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j != i && eligible[j] &&
            ((age[j] < age[i]) || ((age[j] == age[i]) && (j < i)))) begin
          rank[i] = rank[i] + RW'(1);
        end
      end
      grant[i] = eligible[i] && (int'(rank[i]) < NUM_PORTS);
    end
  end

  // Route the request holding rank k onto port k; unused ports carry zeros
  always_comb begin : port_mux
    for (int k = 0; k < NUM_PORTS; k++) begin
      sel_valid[k]   = 1'b0;
      sel_al_idx[k]  = '0;
      sel_uses_rd[k] = 1'b0;
      sel_rd[k]      = '0;
      sel_data[k]    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (int'(rank[i]) == k)) begin
          sel_valid[k]   = 1'b1;
          sel_al_idx[k]  = req_al_idx[i];
          sel_uses_rd[k] = req_uses_rd[i];
          sel_rd[k]      = req_rd[i];
          sel_data[k]    = req_data[i];
        end
      end
    end
  end

  // A source is released when granted or squashed; nothing is released during reset
  always_comb begin : ready_gen
    req_ready = reset ? '0 : (grant | squash);
  end

  // Writeback register: already-issued results are never recalled by a later flush
  always_ff @(posedge clk) begin : wb_reg
    if (reset) begin
      wb_valid   <= '0;
      wb_uses_rd <= '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        wb_al_idx[k] <= '0;
        wb_rd[k]     <= '0;
        wb_data[k]   <= '0;
      end
    end else begin
      wb_valid   <= sel_valid;
      wb_uses_rd <= sel_uses_rd;
      for (int k = 0; k < NUM_PORTS; k++) begin
        wb_al_idx[k] <= sel_al_idx[k];
        wb_rd[k]     <= sel_rd[k];
        wb_data[k]   <= sel_data[k];
      end
    end
  end

  // Saturating count of cycles where more results competed than there are ports
  always_ff @(posedge clk) begin : conflict_counter
    if (reset) begin
      conflict_cnt <= '0;
    end else if ((int'(elig_cnt) > NUM_PORTS) && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios plus randomized traffic, all checked
// against an age-sorting reference model of the writeback arbiter.
module tb_wb_port_arbiter;

  localparam int NUM_REQ   = 6;
  localparam int NUM_PORTS = 4;
  localparam int AL_SIZE   = 64;
  localparam int AW        = 6;
  localparam int PW        = 6;
  localparam int DATA_W    = 64;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [AW-1:0]      req_al_idx  [NUM_REQ];
  logic [NUM_REQ-1:0] req_uses_rd;
  logic [PW-1:0]      req_rd      [NUM_REQ];
  logic [DATA_W-1:0]  req_data    [NUM_REQ];
  logic [AW-1:0]      al_head;
  logic               flush;
  logic [AW-1:0]      flush_al_idx;
  logic [NUM_PORTS-1:0] wb_valid;
  logic [AW-1:0]      wb_al_idx   [NUM_PORTS];
  logic [NUM_PORTS-1:0] wb_uses_rd;
  logic [PW-1:0]      wb_rd       [NUM_PORTS];
  logic [DATA_W-1:0]  wb_data     [NUM_PORTS];
  logic [15:0]        conflict_cnt;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model state: expected registered outputs and counter
  logic [NUM_PORTS-1:0] exp_valid;
  logic [AW-1:0]        exp_al_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] exp_uses_rd;
  logic [PW-1:0]        exp_rd     [NUM_PORTS];
  logic [DATA_W-1:0]    exp_data   [NUM_PORTS];
  int                   model_cnt = 0;

  wb_port_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_PORTS(NUM_PORTS), .AL_SIZE(AL_SIZE),
    .NUM_PR(64), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_al_idx(req_al_idx),
    .req_uses_rd(req_uses_rd), .req_rd(req_rd), .req_data(req_data),
    .al_head(al_head), .flush(flush), .flush_al_idx(flush_al_idx),
    .wb_valid(wb_valid), .wb_al_idx(wb_al_idx), .wb_uses_rd(wb_uses_rd),
    .wb_rd(wb_rd), .wb_data(wb_data), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  tag, observed, expected, $time);
  endtask

  task automatic applyStimulus(input logic rst, input int head, input logic fl,
                               input int fidx);
    reset        = rst;
    al_head      = AW'(head);
    flush        = fl;
    flush_al_idx = AW'(fidx);
  endtask

  task automatic clearReqs();
    req_valid   = '0;
    req_uses_rd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_al_idx[i] = '0;
      req_rd[i]     = '0;
      req_data[i]   = '0;
    end
  endtask

  task automatic setReq(input int i, input int idx, input int rd,
                        input logic [63:0] data);
    req_valid[i]   = 1'b1;
    req_al_idx[i]  = AW'(idx);
    req_uses_rd[i] = 1'b1;
    req_rd[i]      = PW'(rd);
    req_data[i]    = data;
  endtask

  // Model: sort eligible requests by (age, index), take the first NUM_PORTS,
  // check ready this cycle, then check the registered bus after the edge.
  task automatic stepCycle();
    int q[$];
    int a, fage, ri;
    logic [NUM_REQ-1:0] er;
    er = '0;
    exp_valid = '0;
    exp_uses_rd = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      exp_al_idx[k] = '0;
      exp_rd[k]     = '0;
      exp_data[k]   = '0;
    end
    if (reset) begin
      model_cnt = 0;
    end else begin
      fage = (int'(flush_al_idx) - int'(al_head) + AL_SIZE) % AL_SIZE;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i]) begin
          a = (int'(req_al_idx[i]) - int'(al_head) + AL_SIZE) % AL_SIZE;
          if (flush && a > fage) er[i] = 1'b1;
          else q.push_back(a * NUM_REQ + i);
        end
      end
      q.sort();
      for (int k = 0; k < NUM_PORTS && k < q.size(); k++) begin
        ri = q[k] % NUM_REQ;
        er[ri]         = 1'b1;
        exp_valid[k]   = 1'b1;
        exp_al_idx[k]  = req_al_idx[ri];
        exp_uses_rd[k] = req_uses_rd[ri];
        exp_rd[k]      = req_rd[ri];
        exp_data[k]    = req_data[ri];
      end
      if (q.size() > NUM_PORTS && model_cnt < 65535) model_cnt++;
    end
    #1;
    checkOutput("req_ready", 64'(req_ready), 64'(er));
    @(posedge clk);
    #1;
    checkOutput("wb_valid", 64'(wb_valid), 64'(exp_valid));
    checkOutput("wb_uses_rd", 64'(wb_uses_rd), 64'(exp_uses_rd));
    for (int k = 0; k < NUM_PORTS; k++) begin
      checkOutput($sformatf("wb_al_idx[%0d]", k), 64'(wb_al_idx[k]), 64'(exp_al_idx[k]));
      checkOutput($sformatf("wb_rd[%0d]", k), 64'(wb_rd[k]), 64'(exp_rd[k]));
      checkOutput($sformatf("wb_data[%0d]", k), wb_data[k], exp_data[k]);
    end
    checkOutput("conflict_cnt", 64'(conflict_cnt), 64'(model_cnt));
  endtask

  task automatic randomReqs();
    bit used [AL_SIZE];
    int cand;
    for (int j = 0; j < AL_SIZE; j++) used[j] = 1'b0;
    clearReqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      do cand = int'($urandom_range(0, AL_SIZE - 1)); while (used[cand]);
      used[cand] = 1'b1;
      req_valid[i]   = ($urandom_range(0, 3) != 0);
      req_al_idx[i]  = AW'(cand);
      req_uses_rd[i] = $urandom_range(0, 1) == 1;
      req_rd[i]      = PW'($urandom);
      req_data[i]    = {$urandom, $urandom};
    end
  endtask

  initial begin
    clearReqs();
    applyStimulus(1'b1, 0, 1'b0, 0);
    stepCycle();
    stepCycle();

    // Single request
    applyStimulus(1'b0, 0, 1'b0, 0);
    setReq(2, 5, 17, 64'hAB);
    stepCycle();
    checkOutput("single_port0_idx", 64'(wb_al_idx[0]), 64'd5);

    // Oversubscription, then the two deferred requesters drain
    clearReqs();
    setReq(0, 10, 1, 64'h10); setReq(1, 3, 2, 64'h3); setReq(2, 7, 3, 64'h7);
    setReq(3, 1, 4, 64'h1);   setReq(4, 12, 5, 64'h12); setReq(5, 8, 6, 64'h8);
    stepCycle();
    clearReqs();
    setReq(0, 10, 1, 64'h10); setReq(4, 12, 5, 64'h12);
    stepCycle();

    // Wrap-around ordering
    clearReqs();
    applyStimulus(1'b0, 62, 1'b0, 0);
    setReq(0, 1, 7, 64'hA1); setReq(1, 63, 8, 64'hA2); setReq(2, 62, 9, 64'hA3);
    setReq(3, 0, 10, 64'hA4); setReq(4, 5, 11, 64'hA5);
    stepCycle();
    checkOutput("wrap_port0_idx", 64'(wb_al_idx[0]), 64'd62);

    // Flush squashes the younger pair
    clearReqs();
    applyStimulus(1'b0, 0, 1'b1, 6);
    setReq(0, 4, 1, 64'hB0); setReq(1, 6, 2, 64'hB1);
    setReq(2, 9, 3, 64'hB2); setReq(3, 20, 4, 64'hB3);
    stepCycle();

    // Reset mid-stream
    clearReqs();
    applyStimulus(1'b1, 0, 1'b0, 0);
    setReq(0, 1, 1, 64'hC0); setReq(1, 2, 2, 64'hC1); setReq(2, 3, 3, 64'hC2);
    stepCycle();

    // Randomized traffic with occasional flush and reset
    for (int n = 0; n < 400; n++) begin
      randomReqs();
      applyStimulus($urandom_range(0, 49) == 0, int'($urandom_range(0, AL_SIZE - 1)),
                    $urandom_range(0, 4) == 0, int'($urandom_range(0, AL_SIZE - 1)));
      stepCycle();
    end

    // Saturation: six requests held for 70000 cycles from a cleared counter
    clearReqs();
    applyStimulus(1'b1, 0, 1'b0, 0);
    stepCycle();
    applyStimulus(1'b0, 0, 1'b0, 0);
    for (int i = 0; i < NUM_REQ; i++) setReq(i, i * 3, i, 64'(i));
    for (int n = 0; n < 70000; n++) stepCycle();
    checkOutput("conflict_saturated", 64'(conflict_cnt), 64'hFFFF);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
